// File: rtl/eth_pkg.sv
// Ethernet framing constants shared by the MAC transmit and receive paths.
package eth_pkg;

    localparam logic [7:0]  eth_preamble_byte      = 8'h55;
    localparam logic [7:0]  eth_sfd_byte           = 8'hD5;
    localparam int unsigned eth_preamble_length    = 7;
    localparam int unsigned eth_fcs_length         = 4;

    localparam logic [31:0] eth_crc32_poly         = 32'hEDB88320;
    localparam logic [31:0] eth_crc32_residue      = 32'hDEBB20E3;

    // Minimum legal frame length counted after SFD, FCS included.
    localparam int unsigned eth_min_rx_frame_bytes = 64;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 update: folds one byte, LSB first.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] Crc_in,
    input  logic [7:0]  Data_in,
    output logic [31:0] Crc_out
);

    logic [31:0] c;

    // Eight shift/xor steps of the reflected polynomial.
    always_comb begin
        c = Crc_in ^ {24'h000000, Data_in};
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ eth_crc32_poly;
            end else begin
                c = c >> 1;
            end
        end
        Crc_out = c;
    end

endmodule

// File: rtl/mac_1g_rx.sv
// 1G Ethernet receive framer: strips preamble/SFD/FCS, checks CRC and
// length limits, and forwards the frame bytes with an end-of-frame error flag.
module mac_1g_rx
    import eth_pkg::*;
#(
    parameter int unsigned MAX_FRAME_BYTES = 1518
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Mac_valid,
    input  logic [7:0] Mac_data,
    input  logic       Mac_last,
    output logic       Payload_valid,
    output logic [7:0] Payload_data,
    output logic       Payload_last,
    output logic       Payload_error,
    output logic       Stat_frame_ok,
    output logic       Stat_frame_err
);

    localparam int unsigned CNT_W = $clog2(MAX_FRAME_BYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DISCARD
    } rx_state_t;

    rx_state_t         state;
    logic [2:0]        pre_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [3:0][7:0]   dly;
    logic [31:0]       crc;
    logic [31:0]       crc_next;
    logic              frame_bad;
    logic              from_reset;

    eth_crc32_byte u_crc (
        .Crc_in  (crc),
        .Data_in (Mac_data),
        .Crc_out (crc_next)
    );

    // Saturating byte count including the current beat, and the end-of-frame verdict.
    always_comb begin
        cnt_inc   = (byte_cnt == '1) ? byte_cnt : byte_cnt + CNT_W'(1);
        frame_bad = (crc_next != eth_crc32_residue) ||
                    (32'(cnt_inc) < eth_min_rx_frame_bytes);
    end

    // Receive state machine with delay line, CRC register and registered outputs.
    // from_reset suppresses the err pulse when the first post-reset bytes are the
    // tail of a frame cut short by reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= S_IDLE;
            pre_cnt        <= '0;
            byte_cnt       <= '0;
            dly            <= '0;
            crc            <= '1;
            from_reset     <= 1'b1;
            Payload_valid  <= 1'b0;
            Payload_data   <= '0;
            Payload_last   <= 1'b0;
            Payload_error  <= 1'b0;
            Stat_frame_ok  <= 1'b0;
            Stat_frame_err <= 1'b0;
        end else begin
            Payload_valid  <= 1'b0;
            Payload_last   <= 1'b0;
            Payload_error  <= 1'b0;
            Stat_frame_ok  <= 1'b0;
            Stat_frame_err <= 1'b0;
            if (Mac_valid) begin
                case (state)
                    S_IDLE: begin
                        from_reset <= 1'b0;
                        if (Mac_last) begin
                            Stat_frame_err <= 1'b1;
                        end else if (Mac_data == eth_preamble_byte) begin
                            state   <= S_PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state          <= S_DISCARD;
                            Stat_frame_err <= !from_reset;
                        end
                    end
                    S_PREAMBLE: begin
                        if (Mac_last) begin
                            state          <= S_IDLE;
                            Stat_frame_err <= 1'b1;
                        end else if (Mac_data == eth_sfd_byte) begin
                            state    <= S_DATA;
                            byte_cnt <= '0;
                            crc      <= '1;
                        end else if (Mac_data == eth_preamble_byte &&
                                     32'(pre_cnt) < eth_preamble_length) begin
                            pre_cnt <= pre_cnt + 3'd1;
                        end else begin
                            state          <= S_DISCARD;
                            Stat_frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        crc      <= crc_next;
                        dly      <= {dly[2:0], Mac_data};
                        byte_cnt <= cnt_inc;
                        if (Mac_last) begin
                            state <= S_IDLE;
                            if (32'(cnt_inc) <= eth_fcs_length) begin
                                Stat_frame_err <= 1'b1;
                            end else begin
                                Payload_valid  <= 1'b1;
                                Payload_data   <= dly[3];
                                Payload_last   <= 1'b1;
                                Payload_error  <= frame_bad;
                                Stat_frame_ok  <= !frame_bad;
                                Stat_frame_err <= frame_bad;
                            end
                        end else if (32'(byte_cnt) == MAX_FRAME_BYTES) begin
                            state          <= S_DISCARD;
                            Payload_valid  <= 1'b1;
                            Payload_data   <= dly[3];
                            Payload_last   <= 1'b1;
                            Payload_error  <= 1'b1;
                            Stat_frame_err <= 1'b1;
                        end else if (32'(byte_cnt) >= eth_fcs_length) begin
                            Payload_valid <= 1'b1;
                            Payload_data  <= dly[3];
                        end
                    end
                    S_DISCARD: begin
                        if (Mac_last) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_1g_rx.sv
// Directed bench for mac_1g_rx: good/bad-FCS/runt/oversize frames, malformed
// preamble, gapped back-to-back frames and a mid-frame reset.
module tb_mac_1g_rx;

    logic       Clk;
    logic       Rst_n;
    logic       Mac_valid;
    logic [7:0] Mac_data;
    logic       Mac_last;
    logic       Payload_valid;
    logic [7:0] Payload_data;
    logic       Payload_last;
    logic       Payload_error;
    logic       Stat_frame_ok;
    logic       Stat_frame_err;

    mac_1g_rx #(.MAX_FRAME_BYTES(1518)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Mac_valid      (Mac_valid),
        .Mac_data       (Mac_data),
        .Mac_last       (Mac_last),
        .Payload_valid  (Payload_valid),
        .Payload_data   (Payload_data),
        .Payload_last   (Payload_last),
        .Payload_error  (Payload_error),
        .Stat_frame_ok  (Stat_frame_ok),
        .Stat_frame_err (Stat_frame_err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] frm[$];
    logic [7:0] exp_q[$];
    logic [7:0] out_q[$];
    int   ok_cnt   = 0;
    int   err_cnt  = 0;
    int   last_cnt = 0;
    int   last_pos = -1;
    logic last_err = 1'b0;
    int   b_out, b_ok, b_err, b_last;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Capture output bytes and stat pulses away from the active edge.
    always @(negedge Clk) begin
        if (Payload_valid) begin
            out_q.push_back(Payload_data);
            if (Payload_last) begin
                last_cnt = last_cnt + 1;
                last_pos = out_q.size() - 1;
                last_err = Payload_error;
            end
        end
        if (Stat_frame_ok)  ok_cnt  = ok_cnt + 1;
        if (Stat_frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bitwise reference CRC, one input bit at a time.
    function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic build_frame(input int n, input int seed, input bit add_fcs);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        frm.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'(i * 37 + seed * 11 + 1);
            frm.push_back(b);
            c = crc_bits(c, b);
        end
        if (add_fcs) begin
            c = ~c;
            for (int j = 0; j < 4; j++) frm.push_back(c[8*j +: 8]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap_pct);
        for (int g = 0; g < 4 && ($urandom_range(0, 99) < gap_pct); g++) @(negedge Clk);
        Mac_valid = 1'b1;
        Mac_data  = b;
        Mac_last  = last;
        @(negedge Clk);
        Mac_valid = 1'b0;
        Mac_last  = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap_pct);
        for (int i = lo; i < hi; i++) send_byte(frm[i], (i == frm.size() - 1), gap_pct);
    endtask

    task automatic send_preamble(input int gap_pct);
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0, gap_pct);
        send_byte(8'hD5, 1'b0, gap_pct);
    endtask

    task automatic send_frame(input int gap_pct);
        send_preamble(gap_pct);
        send_range(0, frm.size(), gap_pct);
    endtask

    task automatic add_expect(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(frm[i]);
    endtask

    task automatic snap();
        b_out  = out_q.size();
        b_ok   = ok_cnt;
        b_err  = err_cnt;
        b_last = last_cnt;
        exp_q.delete();
    endtask

    task automatic check_result(input string tag, input int e_last, input logic e_perr,
                                input int e_ok, input int e_errp);
        int bad;
        int got;
        repeat (6) @(negedge Clk);
        #1;
        got = out_q.size() - b_out;
        check_val({tag, "_len"}, got, exp_q.size());
        bad = 0;
        for (int i = 0; i < got && i < exp_q.size(); i++)
            if (out_q[b_out + i] !== exp_q[i]) bad++;
        check_val({tag, "_bytes_bad"}, bad, 0);
        check_val({tag, "_nlast"}, last_cnt - b_last, e_last);
        if (e_last > 0) begin
            check_val({tag, "_lastpos"}, last_pos - b_out, exp_q.size() - 1);
            check_val({tag, "_perr"}, last_err, e_perr);
        end
        check_val({tag, "_ok"}, ok_cnt - b_ok, e_ok);
        check_val({tag, "_err"}, err_cnt - b_err, e_errp);
    endtask

    initial begin
        Rst_n     = 1'b0;
        Mac_valid = 1'b0;
        Mac_data  = 8'h00;
        Mac_last  = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check_val("reset_flags", {Payload_valid, Payload_last, Payload_error,
                                  Stat_frame_ok, Stat_frame_err}, 0);
        check_val("reset_data", Payload_data, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Good 60-byte frame (14 header + 46 payload) with correct FCS.
        snap();
        build_frame(60, 1, 1'b1);
        add_expect(60);
        send_frame(0);
        check_result("good", 1, 1'b0, 1, 0);

        // Same frame, one payload bit flipped after the FCS was computed.
        snap();
        build_frame(60, 1, 1'b1);
        frm[20] = frm[20] ^ 8'h04;
        add_expect(60);
        send_frame(0);
        check_result("badfcs", 1, 1'b1, 0, 1);

        // Runt: 40 bytes plus valid FCS.
        snap();
        build_frame(40, 2, 1'b1);
        add_expect(40);
        send_frame(0);
        check_result("runt", 1, 1'b1, 0, 1);

        // Oversize: 1600 bytes after SFD, cut at output byte 1514.
        snap();
        build_frame(1600, 3, 1'b0);
        add_expect(1515);
        send_frame(0);
        check_result("oversize", 1, 1'b1, 0, 1);

        snap();
        build_frame(72, 4, 1'b1);
        add_expect(72);
        send_frame(0);
        check_result("after_over", 1, 1'b0, 1, 0);

        // Malformed preamble, then a good frame.
        snap();
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b1, 0);
        check_result("badpre", 0, 1'b0, 0, 1);

        snap();
        build_frame(64, 5, 1'b1);
        add_expect(64);
        send_frame(0);
        check_result("after_badpre", 1, 1'b0, 1, 0);

        // Three back-to-back gapped frames.
        snap();
        build_frame(60, 6, 1'b1);
        add_expect(60);
        send_frame(20);
        build_frame(97, 7, 1'b1);
        add_expect(97);
        send_frame(20);
        build_frame(61, 8, 1'b1);
        add_expect(61);
        send_frame(20);
        check_result("gaps", 3, 1'b0, 3, 0);

        // Reset mid-frame: tail of the truncated frame is silently discarded.
        build_frame(60, 9, 1'b1);
        send_preamble(0);
        send_range(0, 24, 0);
        Rst_n = 1'b0;
        #1;
        check_val("midrst_flags", {Payload_valid, Payload_last, Payload_error,
                                   Stat_frame_ok, Stat_frame_err}, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        snap();
        frm[24] = 8'h3C;
        send_range(24, frm.size(), 20);
        check_result("rst_tail", 0, 1'b0, 0, 0);

        snap();
        build_frame(80, 10, 1'b1);
        add_expect(80);
        send_frame(20);
        check_result("after_rst", 1, 1'b0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
